piso_shift_register: RTL
========================

// Module: piso_shift_register
// PURPOSE
//  Parallel-in serial-out transmitter: the sending end of the team's 4-bit SIPO serial link.
//  Accepts a WIDTH-bit word over a valid/ready load handshake.
//  Shifts the word out MSB-first, one bit per clk, with a serial_valid qualifier.
//  A SIPO receiver clocked on the same clk and gated by serial_valid rebuilds the word bit-exact.
//  Sits between a parallel data producer and the serial line or the SIPO receiver.
// PARAMETERS
//  WIDTH      4   data word width in bits; legal range 2..32
// PORTS
//  clk           input   1      clock; all state changes on its rising edge
//  reset         input   1      asynchronous, active-high reset
//  load_data     input   WIDTH  parallel word to transmit
//  load_valid    input   1      producer has a word on load_data
//  load_ready    output  1      block can accept a word this cycle
//  serial_out    output  1      current serial bit, MSB first
//  serial_valid  output  1      serial_out carries a data (or parity) bit this cycle
//  tx_last       output  1      high with the final bit of the current word
//  busy          output  1      a word is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (async): state=IDLE, shift_reg=0, bit_cnt=0.
//    Reset output values: serial_out=0, serial_valid=0, tx_last=0, busy=0, load_ready=1.
//  - Accept event: load_valid && load_ready at a rising clk edge.
//    On accept: shift_reg<=load_data, bit_cnt<=0, state<=SHIFT.
//  - All outputs are decoded from registered state; there is no comb path from inputs to outputs
//    except load_ready, which is a state/counter decode only and does not depend on load_valid.
//  - FSM states: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
//    IDLE -> SHIFT on accept; otherwise stay in IDLE.
//    SHIFT, bit_cnt<WIDTH-1: shift_reg<=shift_reg<<1 with 0 filled at the LSB; bit_cnt++.
//    SHIFT, bit_cnt==WIDTH-1 (last data bit):
//      on accept -> reload and stay in SHIFT (back-to-back, no gap cycle);
//      else -> IDLE.
//  - serial_out = shift_reg[WIDTH-1] in SHIFT; 0 in IDLE.
//    serial_valid = (state!=IDLE); busy = serial_valid.
//  - Latency: the first bit (MSB) appears the cycle after accept.
//    A word occupies exactly WIDTH consecutive serial_valid cycles.
//  - tx_last=1 only in the final bit cycle of a word.
//  - load_ready=1 in IDLE and in the final bit cycle of a word; 0 otherwise.
//    load_valid asserted mid-word is ignored (not accepted) and must be held by the producer.
//  - bit_cnt is $clog2(WIDTH) bits wide; it never wraps past WIDTH-1.
//  - Reset asserted mid-word aborts the word immediately.
//    No partial completion; tx_last is not emitted for the aborted word.
//  - load_data is sampled only on accept; later changes do not affect the word in flight.
// CONFIGURATION
//  PISO_PARITY_EN defined:
//    - On accept, the block also registers par = ^load_data (even parity).
//    - After the last data bit the FSM goes SHIFT -> PARITY for one cycle:
//      serial_out=par, serial_valid=1, tx_last=1.
//    - tx_last and load_ready move from the last data bit to the PARITY cycle.
//    - PARITY -> SHIFT on accept, else -> IDLE.
//    - A word then takes WIDTH+1 serial_valid cycles.
//  PISO_PARITY_EN undefined: PARITY state and par register absent; behaviour as above.
// STRUCTURE
//  - piso_pkg: typedef enum logic [1:0] {IDLE, SHIFT, PARITY} piso_state_t;
//    localparam default WIDTH; function cnt_w(width) returning $clog2(width).
//  - Single flat module; no sub-module is natural (FSM, counter and shift register are tightly coupled).
// TESTING
//  1. Reset released, no load_valid -> load_ready=1, serial_valid=0, serial_out=0, busy=0 for 10 cycles.
//  2. Accept 4'b1011 ->
//     - serial_out 1,0,1,1 over 4 cycles with serial_valid=1; tx_last only on the 4th;
//     - load_ready=0 on cycles 1-3 and 1 on the 4th;
//     - idle afterwards.
//  3. Back-to-back 4'b1011 then 4'b0110 (load_valid held) ->
//     8 contiguous valid bits 1,0,1,1,0,1,1,0 with tx_last on bits 4 and 8.
//  4. load_valid pulsed with 4'b1111 during bit 2 of 4'b0001 ->
//     not accepted; output remains 0,0,0,1; 4'b1111 is sent only once the pulse is held into bit 4.
//  5. Reset asserted during bit 2 of 4'b1100 ->
//     outputs return to reset values immediately; a subsequent 4'b0101 is sent correctly as 0,1,0,1.
//  6. Loopback into the 4-bit SIPO gated by serial_valid, 16 random words, incl. 4'b0000 and 4'b1111 ->
//     SIPO parallel_out equals each word on its tx_last cycle+1.
//     With PISO_PARITY_EN, 4'b0111 -> 0,1,1,1 then parity bit 1, with tx_last on the parity bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serial transmitter.
// Holds the FSM state encoding, the default word width and the counter-width helper.
// No logic; imported by piso_shift_register.
package piso_pkg;

    // FSM states. PARITY is only reachable when the parity build option is enabled.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Default data word width; matches the 4-bit SIPO receiver on the other end of the link.
    localparam int PISO_DEFAULT_WIDTH = 4;

    // Width of the bit counter needed to count 0..width-1.
    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake and
// sends it MSB-first, one bit per clk, qualified by serial_valid (first bit the cycle after accept).
// Backpressure: load_ready is high only in IDLE or in the final serial cycle of a word; optional
// even-parity bit appended when PISO_PARITY_EN is defined.
module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             tx_last,
    output logic             busy
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    piso_state_t       state;
    piso_state_t       state_nxt;
    logic [WIDTH-1:0]  shift_reg;
    logic [CW-1:0]     bit_cnt;
    logic              last_data_bit;
    logic              accept;

`ifdef PISO_PARITY_EN
    logic              par;
`endif

    // Decode of the final data bit; the counter never advances past LAST_CNT.
    assign last_data_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);

    // A word is taken whenever the producer offers one while we are ready.
    assign accept = load_valid && load_ready;

    // State register; reset aborts any word in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: reload straight from the last serial cycle to avoid a gap bit.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (last_data_bit) begin
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end else begin
                    state_nxt = SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_nxt = accept ? SHIFT : IDLE;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: everything comes from registered state, nothing from load_valid/load_data.
    always_comb begin
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        tx_last      = 1'b0;
        load_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                serial_out   = shift_reg[WIDTH-1];
                serial_valid = 1'b1;
`ifndef PISO_PARITY_EN
                tx_last      = last_data_bit;
                load_ready   = last_data_bit;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                serial_out   = par;
                serial_valid = 1'b1;
                tx_last      = 1'b1;
                load_ready   = 1'b1;
            end
`endif
            default: begin
                load_ready = 1'b0;
            end
        endcase
        busy = serial_valid;
    end

    // Datapath: capture the word on accept, otherwise shift left one bit per data cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= load_data;
            bit_cnt   <= '0;
        end else if ((state == SHIFT) && !last_data_bit) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CW'(1);
        end
    end

`ifdef PISO_PARITY_EN
    // Even parity of the accepted word, held until the parity cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^load_data;
        end
    end
`endif

endmodule
